mem_loader: RTL and testbench

- Upstream feeder of the D/I memory splitter. Receives a byte stream from the serial receiver, parses framed program/data images and drives the splitter's `in`, `enable` and `selector` inputs.
- Also generates the write address, so one frame fills either data memory or instruction memory from address 0.
- Used at boot and for reload while the core is held in reset.

---
 rtl/mem_loader_pkg.sv | 22 ++
 rtl/loader_timeout.sv | 31 +++
 rtl/mem_loader.sv | 156 +++++++++++++++
 tb/tb_mem_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Shared constants for the boot/reload frame loader and the D/I memory splitter.
package mem_loader_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] TARGET_D  = 8'h00;
   localparam logic [7:0] TARGET_I  = 8'h01;

   localparam logic DIRECT_TO_D = 1'b0;
   localparam logic DIRECT_TO_I = 1'b1;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_TARGET  = 3'd1;
   localparam logic [2:0] ST_LEN_H   = 3'd2;
   localparam logic [2:0] ST_LEN_L   = 3'd3;
   localparam logic [2:0] ST_PAYLOAD = 3'd4;
   localparam logic [2:0] ST_CHECK   = 3'd5;

   function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: counts idle cycles while running, fires once on the LIMIT-th
// idle cycle; a clear in the same cycle suppresses the expiry.
module loader_timeout #(
   parameter int unsigned LIMIT = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expire
);

   localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] count_r;

   assign expire = run && !clear && (count_r == LAST);

   // idle-cycle counter, restarted by any received byte or by leaving a frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= {CW{1'b0}};
      end else if (clear || !run || expire) begin
         count_r <= {CW{1'b0}};
      end else begin
         count_r <= count_r + CW'(1);
      end
   end

endmodule

// File: rtl/mem_loader.sv
// Frame parser feeding the D/I memory splitter: sync, target, 16-bit length,
// payload written from address 0, XOR checksum.
module mem_loader
   import mem_loader_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 10,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_enable,
   output logic                  out_selector,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int IW = ADDR_WIDTH + 1;
   localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_WIDTH);

   logic [2:0]            state_r;
   logic [7:0]            lenh_r;
   logic [7:0]            csum_r;
   logic [IW-1:0]         len_r;
   logic [IW-1:0]         idx_r;
   logic                  sel_r;
   logic                  en_r;
   logic                  done_r;
   logic                  err_r;
   logic [DATA_WIDTH-1:0] data_r;
   logic [ADDR_WIDTH-1:0] addr_r;

   logic [16:0]   len_full_s;
   logic [IW-1:0] idx_next_s;
   logic          expire_s;
   logic          tmo_run_s;

   assign len_full_s = {1'b0, lenh_r, rx_data};
   assign idx_next_s = idx_r + IW'(1);
   assign tmo_run_s  = (state_r != ST_IDLE);

   loader_timeout #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (rx_valid),
      .run    (tmo_run_s),
      .expire (expire_s)
   );

   // frame FSM; a byte always wins over a same-cycle timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         lenh_r  <= 8'h00;
         csum_r  <= 8'h00;
         len_r   <= {IW{1'b0}};
         idx_r   <= {IW{1'b0}};
         sel_r   <= DIRECT_TO_D;
         en_r    <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
         data_r  <= {DATA_WIDTH{1'b0}};
         addr_r  <= {ADDR_WIDTH{1'b0}};
      end else begin
         en_r   <= 1'b0;
         done_r <= 1'b0;
         err_r  <= 1'b0;
         if (rx_valid) begin
            case (state_r)
               ST_IDLE: begin
                  if (rx_data == SYNC_BYTE) begin
                     state_r <= ST_TARGET;
                     csum_r  <= 8'h00;
                  end
               end
               ST_TARGET: begin
                  csum_r <= csum_next(8'h00, rx_data);
                  if (rx_data == TARGET_D) begin
                     sel_r   <= DIRECT_TO_D;
                     state_r <= ST_LEN_H;
                  end else if (rx_data == TARGET_I) begin
                     sel_r   <= DIRECT_TO_I;
                     state_r <= ST_LEN_H;
                  end else begin
                     err_r   <= 1'b1;
                     sel_r   <= DIRECT_TO_D;
                     state_r <= ST_IDLE;
                  end
               end
               ST_LEN_H: begin
                  lenh_r  <= rx_data;
                  csum_r  <= csum_next(csum_r, rx_data);
                  state_r <= ST_LEN_L;
               end
               ST_LEN_L: begin
                  csum_r <= csum_next(csum_r, rx_data);
                  if (len_full_s > MAX_LEN) begin
                     err_r   <= 1'b1;
                     sel_r   <= DIRECT_TO_D;
                     state_r <= ST_IDLE;
                  end else if (len_full_s == 17'd0) begin
                     state_r <= ST_CHECK;
                  end else begin
                     len_r   <= len_full_s[IW-1:0];
                     idx_r   <= {IW{1'b0}};
                     state_r <= ST_PAYLOAD;
                  end
               end
               ST_PAYLOAD: begin
                  en_r   <= 1'b1;
                  data_r <= DATA_WIDTH'(rx_data);
                  addr_r <= idx_r[ADDR_WIDTH-1:0];
                  csum_r <= csum_next(csum_r, rx_data);
                  idx_r  <= idx_next_s;
                  if (idx_next_s == len_r) begin
                     state_r <= ST_CHECK;
                  end
               end
               ST_CHECK: begin
                  if (rx_data == csum_r) begin
                     done_r <= 1'b1;
                  end else begin
                     err_r <= 1'b1;
                  end
                  sel_r   <= DIRECT_TO_D;
                  state_r <= ST_IDLE;
               end
               default: begin
                  sel_r   <= DIRECT_TO_D;
                  state_r <= ST_IDLE;
               end
            endcase
         end else if (expire_s) begin
            err_r   <= 1'b1;
            sel_r   <= DIRECT_TO_D;
            state_r <= ST_IDLE;
         end
      end
   end

   assign out_data     = data_r;
   assign out_enable   = en_r;
   assign out_selector = sel_r;
   assign out_addr     = addr_r;
   assign busy         = (state_r != ST_IDLE);
   assign done         = done_r;
   assign error        = err_r;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: directed frames plus random frames, each byte's expected
// outputs derived from its position in the frame.
module tb_mem_loader;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic [DW-1:0] out_data;
   logic          out_enable;
   logic          out_selector;
   logic [AW-1:0] out_addr;
   logic          busy;
   logic          done;
   logic          error;

   always #5 clk = ~clk;

   mem_loader #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .out_data     (out_data),
      .out_enable   (out_enable),
      .out_selector (out_selector),
      .out_addr     (out_addr),
      .busy         (busy),
      .done         (done),
      .error        (error)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]    frame_q[$];
   logic          exp_en[$];
   logic [7:0]    exp_data[$];
   logic [AW-1:0] exp_addr[$];
   logic          exp_done[$];
   logic          exp_err[$];
   logic          exp_busy[$];
   logic          exp_sel[$];

   logic [7:0]    last_data = 8'h00;
   logic [AW-1:0] last_addr = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic en, input logic [7:0] d,
                             input logic [AW-1:0] a, input logic dn, input logic er,
                             input logic bz, input logic sl);
      if (en) begin
         last_data = d;
         last_addr = a;
      end
      check({tag, ".enable"}, 32'(out_enable), 32'(en));
      check({tag, ".data"}, 32'(out_data), 32'(last_data));
      check({tag, ".addr"}, 32'(out_addr), 32'(last_addr));
      check({tag, ".done"}, 32'(done), 32'(dn));
      check({tag, ".error"}, 32'(error), 32'(er));
      check({tag, ".busy"}, 32'(busy), 32'(bz));
      check({tag, ".selector"}, 32'(out_selector), 32'(sl));
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] xsum_from1();
      logic [7:0] x = 8'h00;
      for (int i = 1; i < frame_q.size(); i++) x ^= frame_q[i];
      return x;
   endfunction

   // Expected outputs per byte, from the byte's position: 0 sync, 1 target,
   // 2..3 length, then payload, then checksum.
   function automatic void predict();
      int         len = -1;
      int         term = -1;
      logic [7:0] tgt = 8'h00;
      logic [7:0] lenh = 8'h00;
      logic [7:0] cs = 8'h00;
      logic       tgt_ok = 1'b0;
      exp_en.delete(); exp_data.delete(); exp_addr.delete();
      exp_done.delete(); exp_err.delete(); exp_busy.delete(); exp_sel.delete();
      for (int k = 0; k < frame_q.size(); k++) begin
         logic [7:0]    b = frame_q[k];
         logic          en = 1'b0, dn = 1'b0, er = 1'b0;
         logic [7:0]    d = 8'h00;
         logic [AW-1:0] a = '0;
         if (k == 1) begin
            tgt = b; cs = b; tgt_ok = (b <= 8'h01);
            if (!tgt_ok) begin er = 1'b1; term = k; end
         end else if (k == 2) begin
            lenh = b; cs ^= b;
         end else if (k == 3) begin
            len = int'({lenh, b}); cs ^= b;
            if (len > (1 << AW)) begin er = 1'b1; term = k; end
         end else if (k >= 4 && k < 4 + len) begin
            en = 1'b1; d = b; a = AW'(k - 4); cs ^= b;
         end else if (k >= 4 && k == 4 + len) begin
            dn = (b == cs); er = (b != cs); term = k;
         end
         exp_en.push_back(en);   exp_data.push_back(d);  exp_addr.push_back(a);
         exp_done.push_back(dn); exp_err.push_back(er);
         exp_busy.push_back(k != term);
         exp_sel.push_back((k >= 1 && tgt_ok && k != term) ? tgt[0] : 1'b0);
      end
   endfunction

   task automatic play(input string tag, input int maxgap);
      int gap;
      predict();
      for (int k = 0; k < frame_q.size(); k++) begin
         send(frame_q[k]);
         expect_out(tag, exp_en[k], exp_data[k], exp_addr[k], exp_done[k], exp_err[k],
                    exp_busy[k], exp_sel[k]);
         gap = int'($urandom_range(maxgap, 0));
         repeat (gap) begin
            idle_cycle();
            expect_out({tag, ".gap"}, 1'b0, 8'h00, '0, 1'b0, 1'b0, exp_busy[k], exp_sel[k]);
         end
      end
   endtask

   task automatic noise(input string tag, input int n);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom);
         if (b == 8'hA5) b = 8'h5A;
         send(b);
         expect_out(tag, 1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      int         r;
      int         len;
      logic [7:0] tgt;
      logic [7:0] cs;

      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      #1;
      expect_out("reset", 1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      noise("idle_noise", 3);

      frame_q = {8'hA5, 8'h01, 8'h00, 8'h02, 8'h11, 8'h22, 8'h30};
      play("i_frame", 2);
      frame_q = {8'hA5, 8'h00, 8'h00, 8'h01, 8'h7E, 8'h00};
      play("d_bad_csum", 2);
      frame_q = {8'hA5, 8'h02};
      play("bad_target", 1);
      frame_q = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
      play("empty", 1);
      frame_q = {8'hA5, 8'h01, 8'h00, 8'h11};
      play("overlength", 1);
      frame_q = {8'hA5, 8'h01, 8'h00, 8'h01, 8'h55, 8'h55};
      play("after_overlength", 1);

      // exactly 2**AW bytes, including 0xA5 as data
      frame_q = {8'hA5, 8'h00, 8'h00, 8'h10};
      for (int i = 0; i < 16; i++) frame_q.push_back((i == 5) ? 8'hA5 : 8'(i * 7 + 3));
      frame_q.push_back(xsum_from1());
      play("max_len", 0);

      frame_q = {8'hA5, 8'h01, 8'h00};
      play("timeout", 0);
      for (int i = 0; i < TO - 1; i++) begin
         idle_cycle();
         expect_out("timeout.wait", 1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      end
      idle_cycle();
      expect_out("timeout.expire", 1'b0, 8'h00, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle_cycle();
      expect_out("timeout.after", 1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      frame_q = {8'hA5, 8'h00, 8'h00, 8'h01, 8'h99, 8'h98};
      play("after_timeout", 2);

      // async reset while a write strobe is high, between payload bytes
      frame_q = {8'hA5, 8'h00, 8'h00, 8'h03, 8'hAA};
      play("pre_reset", 0);
      #2;
      rst = 1'b1;
      #1;
      last_data = 8'h00;
      last_addr = '0;
      expect_out("async_reset", 1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_cycle();
      expect_out("in_reset", 1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      frame_q = {8'hBB, 8'hCC, 8'hDE};
      for (int k = 0; k < 3; k++) begin
         send(frame_q[k]);
         expect_out("post_reset_tail", 1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      for (int f = 0; f < 40; f++) begin
         noise("rand_noise", int'($urandom_range(2, 0)));
         frame_q = {8'hA5};
         r = int'($urandom_range(9, 0));
         tgt = (r == 0) ? 8'($urandom_range(255, 2)) : {7'd0, r[0]};
         frame_q.push_back(tgt);
         if (tgt <= 8'h01) begin
            r = int'($urandom_range(20, 0));
            len = (r == 20) ? 17 + int'($urandom_range(300, 0)) : (r % 17);
            frame_q.push_back(8'(len >> 8));
            frame_q.push_back(8'(len));
            if (len <= 16) begin
               for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
               cs = xsum_from1();
               if ($urandom_range(3, 0) == 0) cs ^= 8'(1 << $urandom_range(7, 0));
               frame_q.push_back(cs);
            end
         end
         play("random", 3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
